// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter, one grant held until done/req drop; optional hold limit via ARB_TIMEOUT_EN
module rr_arbiter_8 #(
   parameter int N        = 8,
   parameter int IDX_W    = 3,
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;
   logic [IDX_W-1:0] ptr, win, j, nxt;
   logic rel, lim;
   if (N < 2 || N > 16 || IDX_W != $clog2(N) || MAX_HOLD < 2) begin : g_bad
      $error("rr_arbiter_8: illegal parameter set");
   end
   // rotating priority search: scan from ptr upward, lowest offset wins
   always_comb begin
      win = ptr;
      j = '0;
      for (int k = N-1; k >= 0; k--) begin
         j = IDX_W'((int'(ptr) + k) % N);
         win = req[j] ? j : win;
      end
   end
   assign nxt = (int'(gnt_idx) == N-1) ? '0 : gnt_idx + 1'b1;
   assign rel = done || !req[gnt_idx];
`ifdef ARB_TIMEOUT_EN
   localparam int HW = $clog2(MAX_HOLD);
   logic [HW-1:0] hold_cnt;
   assign lim = (int'(hold_cnt) == MAX_HOLD-1);
`else
   assign lim = 1'b0;
   assign timeout = 1'b0;
`endif
   // grant FSM: IDLE picks a winner, BUSY holds it until release or hold limit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt <= '0;
         gnt_idx <= '0;
         gnt_valid <= 1'b0;
         ptr <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt <= '0;
         timeout <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout <= 1'b0;
`endif
         if (state == IDLE) begin
            if (|req) begin
               gnt <= N'(1) << win;
               gnt_idx <= win;
               gnt_valid <= 1'b1;
               state <= BUSY;
`ifdef ARB_TIMEOUT_EN
               hold_cnt <= '0;
`endif
            end
         end else if (rel || lim) begin
            gnt <= '0;
            gnt_valid <= 1'b0;
            ptr <= nxt;
            state <= IDLE;
`ifdef ARB_TIMEOUT_EN
            timeout <= !rel;
`endif
         end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed scenarios plus random traffic against a behavioural round-robin model
module tb_rr_arbiter_8;
   logic       clk = 1'b0, rst_n = 1'b0, done = 1'b0;
   logic [7:0] req = '0, gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid, timeout;
   int n_vec = 0, n_err = 0;
   bit m_busy = 0, m_to = 0;
   int m_idx = 0, m_ptr = 0, m_hold = 0;
   int q[$];
   int bc, tc;
   bit prev;
   logic [7:0] r;

   rr_arbiter_8 dut (.clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
                     .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout));

   always #5 clk = ~clk;

   function automatic int winner(input logic [7:0] rq, input int p);
      logic [15:0] d;
      int w;
      d = {rq, rq} >> p;
      w = -1;
      for (int i = 7; i >= 0; i--) if (d[i]) w = (p + i) % 8;
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic cyc(input logic [7:0] rq, input logic d, input logic rn);
      int w;
      req = rq; done = d; rst_n = rn;
      @(posedge clk);
      if (!rn) begin
         m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (!m_busy) begin
            w = winner(rq, m_ptr);
            if (w >= 0) begin m_busy = 1; m_idx = w; m_hold = 0; end
         end else if (d || !rq[m_idx]) begin
            m_busy = 0; m_ptr = (m_idx + 1) % 8;
         end
`ifdef ARB_TIMEOUT_EN
         else if (m_hold == 15) begin
            m_busy = 0; m_ptr = (m_idx + 1) % 8; m_to = 1;
         end
`endif
         else m_hold++;
      end
      #1;
      chk("gnt", 32'(gnt), m_busy ? 32'(1) << m_idx : 32'd0);
      chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
      chk("timeout", 32'(timeout), 32'(m_to));
   endtask

   initial begin
      cyc(8'h00, 0, 0);
      cyc(8'h00, 1, 1);
      // rotation with done two cycles into each grant
      q.delete(); bc = 0; prev = 0;
      repeat (30) begin
         cyc(8'b01100011, bc == 2, 1);
         if (gnt_valid && !prev) q.push_back(int'(gnt_idx));
         prev = gnt_valid;
         bc = m_busy ? bc + 1 : 0;
      end
      chk("rot_count", 32'(q.size() >= 5), 32'd1);
      chk("rot0", 32'(q[0]), 32'd0);
      chk("rot1", 32'(q[1]), 32'd1);
      chk("rot2", 32'(q[2]), 32'd5);
      chk("rot3", 32'(q[3]), 32'd6);
      chk("rot4", 32'(q[4]), 32'd0);
      // requester drops its request
      cyc(8'h00, 0, 0);
      cyc(8'b00011011, 0, 1);
      cyc(8'b00011010, 0, 1);
      chk("drop_released", 32'(gnt_valid), 32'd0);
      cyc(8'b00011010, 0, 1);
      chk("drop_next", 32'(gnt_idx), 32'd1);
      // wrap-around between idx 7 and 0
      cyc(8'h00, 0, 0);
      q.delete(); bc = 0; prev = 0;
      repeat (9) begin
         cyc(8'b10000001, bc == 1, 1);
         if (gnt_valid && !prev) q.push_back(int'(gnt_idx));
         prev = gnt_valid;
         bc = m_busy ? bc + 1 : 0;
      end
      chk("wrap0", 32'(q[0]), 32'd0);
      chk("wrap1", 32'(q[1]), 32'd7);
      chk("wrap2", 32'(q[2]), 32'd0);
      // reset in the middle of a grant
      cyc(8'h00, 0, 0);
      cyc(8'b00100000, 0, 1);
      chk("pre_rst_idx", 32'(gnt_idx), 32'd5);
      cyc(8'b11100011, 0, 0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      cyc(8'b11100011, 0, 1);
      chk("post_rst_idx", 32'(gnt_idx), 32'd0);
      // done coinciding with a dropped request, then re-request
      cyc(8'h00, 0, 0);
      cyc(8'h01, 0, 1);
      cyc(8'h00, 1, 1);
      cyc(8'h00, 0, 1);
      cyc(8'h01, 0, 1);
      chk("regrant", 32'(gnt), 32'h01);
      // long hold with no done
      cyc(8'h00, 0, 0);
      tc = 0;
      repeat (120) begin
         cyc(8'b00010011, 0, 1);
         tc += int'(timeout);
      end
`ifdef ARB_TIMEOUT_EN
      chk("timeouts", 32'(tc), 32'd7);
`else
      chk("held", 32'(gnt_valid && gnt_idx == 3'd0), 32'd1);
      chk("no_timeout", 32'(tc), 32'd0);
`endif
      // random traffic
      r = 8'($urandom);
      repeat (500) begin
         if ($urandom_range(0, 3) == 0) r = 8'($urandom & $urandom);
         cyc(r, $urandom_range(0, 3) == 0, $urandom_range(0, 63) != 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
